// File: rtl/pc_gen_ras.sv
// pc_gen_ras: fetch PC generator with fixed-priority next-PC select and a circular return-address stack
module pc_gen_ras #(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    INSTR_BYTES  = 4,
    parameter int                    RAS_DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          stall,
    input  logic                          redirect_valid,
    input  logic [DATA_WIDTH-1:0]         redirect_target,
    input  logic                          trap_valid,
    input  logic [DATA_WIDTH-1:0]         trap_vector,
    input  logic                          pred_call,
    input  logic [DATA_WIDTH-1:0]         pred_call_target,
    input  logic                          pred_ret,
    output logic [DATA_WIDTH-1:0]         pc,
    output logic [DATA_WIDTH-1:0]         pc_plus,
    output logic                          pc_valid,
    output logic [$clog2(RAS_DEPTH):0]    ras_count,
    output logic                          ras_empty
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_WIDTH-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]         tp;
    logic [PW-1:0]         tp_top;
    logic [DATA_WIDTH-1:0] top;
    logic [DATA_WIDTH-1:0] pc_nxt;
    logic                  act;
    logic                  do_call;
    logic                  do_ret;

    assign pc_plus   = pc + DATA_WIDTH'(INSTR_BYTES);
    assign ras_empty = ras_count == '0;
    // tp points at the next free slot; the top entry sits just below it
    assign tp_top    = tp - 1'b1;
    assign top       = ras[tp_top];
    assign act       = pc_valid && !trap_valid && !redirect_valid && !stall;
    assign do_call   = act && pred_call;
    assign do_ret    = act && pred_ret && !ras_empty;

    always_comb
        pc_nxt = !pc_valid      ? pc :
                 trap_valid     ? trap_vector :
                 redirect_valid ? redirect_target :
                 stall          ? pc :
                 do_ret         ? top :
                 pred_call      ? pred_call_target : pc_plus;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pc        <= RESET_VECTOR;
            pc_valid  <= 1'b0;
            tp        <= '0;
            ras_count <= '0;
        end else begin
            pc       <= pc_nxt;
            pc_valid <= 1'b1;
            if (pc_valid && trap_valid) begin
                tp        <= '0;
                ras_count <= '0;
            end else if (do_call && !do_ret) begin
                tp        <= tp + 1'b1;
                ras_count <= ras_count == CW'(RAS_DEPTH) ? ras_count : ras_count + 1'b1;
            end else if (do_ret && !do_call) begin
                tp        <= tp_top;
                ras_count <= ras_count - 1'b1;
            end
        end

    // a call with a simultaneous return overwrites the top in place
    always_ff @(posedge clk)
        if (do_call)
            ras[do_ret ? tp_top : tp] <= pc_plus;
endmodule

// File: doc/pc_gen_ras.md
# pc_gen_ras

Parametrised program-counter generator for the pipelined RISC-V core, replacing the plain PC register in the fetch stage. It holds the fetch PC and selects the next PC from a fixed-priority set of sources: trap vector, execute-stage redirect, stall hold, predicted return, predicted call, and sequential. It contains a circular return-address stack (RAS) of configurable depth, so call/return prediction resolves in the cycle the decode hint is given.

## Interface
- DATA_WIDTH, 32: PC and target width in bits.
- RESET_VECTOR, 32'h0000_0000: PC value held during reset and on the first valid fetch.
- INSTR_BYTES, 4: sequential increment and return-address offset.
- RAS_DEPTH, 4: number of RAS entries; must be a power of 2 and at least 2.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- stall  in  1  hold the PC and RAS.
- redirect_valid  in  1  execute-stage branch/jump resolution.
- redirect_target  in  DATA_WIDTH  redirect address.
- trap_valid  in  1  exception or interrupt entry.
- trap_vector  in  DATA_WIDTH  trap handler address.
- pred_call  in  1  the instruction at pc is a call.
- pred_call_target  in  DATA_WIDTH  call target.
- pred_ret  in  1  the instruction at pc is a return.
- pc  out  DATA_WIDTH  current fetch PC, registered.
- pc_plus  out  DATA_WIDTH  pc + INSTR_BYTES, combinational from pc.
- pc_valid  out  1  pc is a valid fetch address, registered.
- ras_count  out  $clog2(RAS_DEPTH)+1  number of occupied RAS entries, registered.
- ras_empty  out  1  ras_count == 0.

## Operation
- Next-PC priority, highest first:
  1. trap_valid: pc <= trap_vector; the RAS is cleared (count 0).
  2. redirect_valid: pc <= redirect_target; the RAS is unchanged (no repair).
  3. stall: pc and RAS hold.
  4. pred_ret with the RAS non-empty: pc <= top of RAS.
  5. pred_call: pc <= pred_call_target.
  6. Otherwise: pc <= pc + INSTR_BYTES.
- RAS actions apply only when priorities 1–3 are inactive:
  - pred_call alone: push pc + INSTR_BYTES.
  - pred_ret alone, RAS non-empty: pop.
  - pred_ret alone, RAS empty: no pop; pc takes the sequential value.
  - pred_call and pred_ret together, RAS non-empty: pc <= old top. The top entry is replaced with pc + INSTR_BYTES; count is unchanged (coroutine pop-then-push).
  - pred_call and pred_ret together, RAS empty: behaves as pred_call alone.
- RAS full on push: the oldest entry is overwritten (circular top pointer) and count saturates at RAS_DEPTH. A later pop still returns the newest entries in LIFO order.
- Arithmetic is modulo 2^DATA_WIDTH: a PC at the top of the address space wraps to 0. Targets are used unmodified; alignment is checked elsewhere.
- While pc_valid = 0, all request inputs are ignored.

## Timing
- Reset (rst_n low) takes effect immediately, without waiting for a clock edge:
  - pc = RESET_VECTOR
  - pc_plus = RESET_VECTOR + INSTR_BYTES
  - pc_valid = 0
  - ras_count = 0, ras_empty = 1
  - RAS pointer = 0 (entry contents don't-care)
- First rising edge after rst_n goes high: pc_valid <= 1 and pc stays at RESET_VECTOR. The first valid fetch is therefore at RESET_VECTOR.
- From then on, every input sampled at edge N is reflected in pc, ras_count and ras_empty after edge N. The latency is 1 cycle and no bubble is inserted.
- The RAS top is read combinationally from current state, so a push at edge N followed by a return at edge N+1 targets the pushed address.
- If rst_n is asserted mid-operation, all state returns to its reset values asynchronously, regardless of any pending stall, trap or RAS activity.

## Test plan
- Reset with RESET_VECTOR=32'h100:
  - During reset: pc=32'h100, pc_valid=0.
  - At edge 1: pc=32'h100, pc_valid=1.
  - Edges 2 and 3 give 32'h104 and 32'h108.
- Priority:
  - At pc=32'h200, assert trap_valid (trap_vector=32'h80), redirect_valid, stall and pred_call together: next pc=32'h80 and ras_count=0.
  - Redirect together with stall (redirect_target=32'h300): pc=32'h300.
- Call/return pair:
  - pred_call at pc=32'h40 with target 32'h1000: pc=32'h1000, ras_count=1.
  - Two sequential cycles, then pred_ret: pc=32'h44, ras_count=0.
  - pred_ret on the empty RAS: pc advances sequentially and count stays 0.
- Overflow with RAS_DEPTH=4: perform 5 calls pushing return addresses A1..A5, then 5 returns.
  - ras_count=4 after the calls.
  - Return targets are A5, A4, A3, A2; the 5th return finds the RAS empty and goes sequential.
- Corner cases:
  - Simultaneous pred_call and pred_ret with top=32'h500 at pc=32'h600: pc=32'h500, top becomes 32'h604, count unchanged.
  - Stall asserted with pred_call: pc and ras_count unchanged.
- Mid-operation reset: with pc=32'hFFFF_FFFC and 3 entries on the RAS, pulse rst_n low between edges.
  - Immediately: pc=RESET_VECTOR, pc_valid=0, ras_count=0.
  - Separately, without reset, a sequential step from 32'hFFFF_FFFC wraps pc to 32'h0.
